// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch front end: request/grant memory port, in-order prefetch FIFO, redirect kill.
// Optional macro FETCH_BYPASS_EN: a response reaching an empty FIFO is offered to decode the same cycle.
module riscv_fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4,
  parameter int              MAX_OUTST  = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CR_W  = CNT_W + 1;

  logic [XLEN-1:0]  r_fetch_pc;
  logic [XLEN-1:0]  r_resp_pc;
  logic [CNT_W-1:0] r_outst_cnt;
  logic [CNT_W-1:0] r_kill_cnt;
  logic [CNT_W-1:0] r_fifo_cnt;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [XLEN-1:0]  r_fifo_pc   [FIFO_DEPTH];
  logic [XLEN-1:0]  r_fifo_data [FIFO_DEPTH];

  logic [CR_W-1:0]  w_credit;
  logic             w_grant;
  logic             w_fifo_empty;
  logic             w_byp_avail;
  logic             w_bypass_take;
  logic             w_live;
  logic             w_push;
  logic             w_pop;
  logic [XLEN-1:0]  w_redirect_aligned;

  // Outstanding requests (killed ones included) hold a FIFO slot, so a live response always fits.
  assign w_credit     = {1'b0, r_outst_cnt} + {1'b0, r_fifo_cnt};
  assign imem_req     = !rst && !redirect_valid
                        && (r_outst_cnt < CNT_W'(MAX_OUTST))
                        && (w_credit < CR_W'(FIFO_DEPTH));
  assign imem_addr    = r_fetch_pc;
  assign w_grant      = imem_req && imem_gnt;
  assign w_fifo_empty = (r_fifo_cnt == '0);
  assign w_redirect_aligned = redirect_pc & ~XLEN'(3);

`ifdef FETCH_BYPASS_EN
  assign w_byp_avail = w_fifo_empty && (r_kill_cnt == '0) && imem_rvalid;
`else
  assign w_byp_avail = 1'b0;
`endif

  assign inst_valid    = (!w_fifo_empty || w_byp_avail) && !redirect_valid;
  assign inst_pc       = !w_fifo_empty ? r_fifo_pc[r_rd_ptr]
                       : (w_byp_avail ? r_resp_pc : '0);
  assign inst_data     = !w_fifo_empty ? r_fifo_data[r_rd_ptr]
                       : (w_byp_avail ? imem_rdata : '0);

  assign w_bypass_take = w_byp_avail && !redirect_valid && inst_ready;
  assign w_live        = imem_rvalid && (r_kill_cnt == '0);
  assign w_push        = w_live && !redirect_valid && !w_bypass_take;
  assign w_pop         = !w_fifo_empty && !redirect_valid && inst_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]   <= r_resp_pc;
      r_fifo_data[r_wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc  <= RESET_PC;
      r_resp_pc   <= RESET_PC;
      r_outst_cnt <= '0;
      r_kill_cnt  <= '0;
      r_fifo_cnt  <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
    end else if (redirect_valid) begin
      // A response landing in the redirect cycle is already stale, so it is not counted as a kill.
      r_fetch_pc  <= w_redirect_aligned;
      r_resp_pc   <= w_redirect_aligned;
      r_outst_cnt <= r_outst_cnt - CNT_W'(imem_rvalid);
      r_kill_cnt  <= r_outst_cnt - CNT_W'(imem_rvalid);
      r_fifo_cnt  <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
    end else begin
      if (w_grant) begin
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
      r_outst_cnt <= r_outst_cnt + CNT_W'(w_grant) - CNT_W'(imem_rvalid);
      if (imem_rvalid) begin
        if (r_kill_cnt != '0) begin
          r_kill_cnt <= r_kill_cnt - CNT_W'(1);
        end else begin
          r_resp_pc <= r_resp_pc + XLEN'(4);
        end
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_fifo_cnt <= r_fifo_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed bench for riscv_fetch_unit: in-order memory model plus a scoreboard of granted fetches.
module tb_riscv_fetch_unit;

  localparam int MAX_OUTST = 2;
`ifdef FETCH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;

  always #5 clk = ~clk;

  riscv_fetch_unit #(
    .XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(4), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_pc(inst_pc), .inst_data(inst_data)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_pops = 0;
  logic [31:0] mem_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] exp_fetch = 32'h0;
  logic        gnt_en = 1'b0;
  logic        rsp_en = 1'b1;
  logic        s_req, s_iv;
  logic [31:0] s_addr, s_pc, s_data;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive memory, sample outputs, update models, advance to the next negedge.
  task automatic tick();
    logic [63:0] e;
    imem_gnt    = gnt_en;
    imem_rvalid = rsp_en && (mem_q.size() > 0);
    imem_rdata  = imem_rvalid ? mem_word(mem_q[0]) : 32'h0;
    #1;
    s_req = imem_req; s_addr = imem_addr;
    s_iv = inst_valid; s_pc = inst_pc; s_data = inst_data;
    if (s_iv && inst_ready) begin
      n_pops++;
      check("pop_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("inst_pc", s_pc, e[63:32]);
        check("inst_data", s_data, e[31:0]);
      end
      $display("pop   pc=%h data=%h", s_pc, s_data);
    end
    if (redirect_valid) begin
      exp_q.delete();
      exp_fetch = redirect_pc & ~32'h3;
      $display("redir pc=%h", redirect_pc);
    end
    if (imem_rvalid) mem_q.delete(0);
    if (s_req && imem_gnt) begin
      check("fetch_addr", s_addr, exp_fetch);
      exp_fetch += 32'd4;
      mem_q.push_back(s_addr);
      exp_q.push_back({s_addr, mem_word(s_addr)});
      check("outstanding_le_max", 32'(mem_q.size() <= MAX_OUTST), 32'd1);
      $display("grant addr=%h", s_addr);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
    mem_q.delete(); exp_q.delete(); exp_fetch = 32'h0;
    #1;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_inst_data", inst_data, 32'h0);
    $display("reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int p0;
    do_reset();

    // Grant withheld: request and address must hold.
    inst_ready = 1'b1; gnt_en = 1'b0; rsp_en = 1'b1;
    repeat (3) begin
      tick();
      check("stall_req", 32'(s_req), 32'd1);
      check("stall_addr", s_addr, 32'h0);
    end
    // Streaming fetch, one-cycle memory latency.
    gnt_en = 1'b1;
    repeat (12) tick();

    // Decode stalled: FIFO fills to four and fetch stops at 0x10.
    do_reset();
    inst_ready = 1'b0; gnt_en = 1'b1; rsp_en = 1'b1;
    repeat (6) tick();
    check("full_req", 32'(s_req), 32'd0);
    check("full_addr", s_addr, 32'h10);
    check("full_valid", 32'(s_iv), 32'd1);
    check("full_head_pc", s_pc, 32'h0);
    inst_ready = 1'b1;
    repeat (10) tick();

    // Redirect with 0x8 and 0xC in flight.
    do_reset();
    inst_ready = 1'b1; gnt_en = 1'b1; rsp_en = 1'b1;
    repeat (3) tick();
    rsp_en = 1'b0;
    tick();
    check("pre_redir_last_grant", s_addr, 32'hC);
    check("pre_redir_in_flight", 32'(mem_q.size()), 32'd2);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    check("redir_req", 32'(s_req), 32'd0);
    check("redir_valid", 32'(s_iv), 32'd0);
    redirect_valid = 1'b0; rsp_en = 1'b1;
    p0 = n_pops;
    repeat (8) tick();
    check("pops_after_redir", 32'((n_pops - p0) >= 2), 32'd1);

    // Redirect coinciding with a response and a ready decode; unaligned target.
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    tick();
    check("redir2_req", 32'(s_req), 32'd0);
    check("redir2_valid", 32'(s_iv), 32'd0);
    redirect_valid = 1'b0;
    tick();
    check("redir2_req_next", 32'(s_req), 32'd1);
    check("redir2_addr_next", s_addr, 32'h200);
    repeat (6) tick();

    // Empty FIFO latency from response to decode.
    gnt_en = 1'b0;
    repeat (4) tick();
    gnt_en = 1'b1;
    tick();
    gnt_en = 1'b0;
    tick();
    check("lat_rvalid_cycle", 32'(s_iv), 32'(BYP));
    tick();
    check("lat_next_cycle", 32'(s_iv), 32'(!BYP));

    repeat (3) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: no finish within time limit (observed running, expected done)");
    $fatal(1, "timeout");
  end

endmodule
